// File: rtl/hp35_rom_loader.sv
// Serial ROM-image loader: deserialises an externally clocked bit stream into
// 32-bit words and writes them sequentially into SRAM port 0 with a 2-cycle strobe.
module hp35_rom_loader #(
   parameter int WORDS = 256
) (
   input  logic        osc_in,
   input  logic        rst_n,
   input  logic        sload,
   input  logic        wclk,
   input  logic        sdin,
   output logic        sram_csb0,
   output logic        sram_web0,
   output logic [7:0]  sram_addr0,
   output logic [31:0] sram_din0,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [8:0]  word_cnt
);

   typedef enum logic [1:0] {IDLE, SHIFT, WR, FIN} state_t;

   localparam logic [8:0] WORDS_L = 9'(WORDS);

   state_t      state, state_nx;
   logic [1:0]  sload_s, wclk_s, sdin_s;
   logic        sload_d, wclk_d;
   logic        sload_rise, sload_fall, bit_ev, bit_val;
   // Only 31 bits are stored: the 32nd bit goes straight into sram_din0.
   logic [30:0] shreg;
   logic [4:0]  bit_cnt;
   logic [1:0]  wr_ph;
   logic        wr_pend, closing, rearm, ovf;
   logic        wr_last, wr_restart, wr_close, start, shifting;

   // sdin shares the two-flop depth of wclk so data and bit event line up
   always_ff @(posedge osc_in or negedge rst_n) begin
      if (!rst_n) begin
         sload_s <= '0;
         wclk_s  <= '0;
         sdin_s  <= '0;
         sload_d <= 1'b0;
         wclk_d  <= 1'b0;
      end else begin
         sload_s <= {sload_s[0], sload};
         wclk_s  <= {wclk_s[0], wclk};
         sdin_s  <= {sdin_s[0], sdin};
         sload_d <= sload_s[1];
         wclk_d  <= wclk_s[1];
      end
   end

   assign sload_rise = sload_s[1] & ~sload_d;
   assign sload_fall = ~sload_s[1] & sload_d;
   assign bit_ev     = wclk_s[1] & ~wclk_d;
   assign bit_val    = sdin_s[1];

   assign shifting   = (state == SHIFT) || (state == WR);
   assign wr_last    = (state == WR) && (wr_ph == 2'd2);
   assign wr_restart = (rearm & ~sload_fall) | sload_rise;
   assign wr_close   = (closing & ~sload_rise) | sload_fall;
   // A re-arm seen during WR is deferred until the strobe has finished
   assign start      = (sload_rise && (state != WR)) || (wr_last && wr_restart);

   always_ff @(posedge osc_in or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (sload_rise) state_nx = SHIFT;
         SHIFT: begin
            if (sload_rise)      state_nx = SHIFT;
            else if (sload_fall) state_nx = FIN;
            else if (wr_pend)    state_nx = WR;
         end
         WR: begin
            if (wr_last) begin
               if (wr_restart)    state_nx = SHIFT;
               else if (wr_close) state_nx = FIN;
               else               state_nx = SHIFT;
            end
         end
         FIN: begin
            if (sload_rise)   state_nx = SHIFT;
            else if (wr_pend) state_nx = WR;
            else              state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      sram_csb0 = 1'b1;
      sram_web0 = 1'b1;
      busy      = (state != IDLE);
      if (state == WR && wr_ph != 2'd2) begin
         sram_csb0 = 1'b0;
         sram_web0 = 1'b0;
      end
   end

   always_ff @(posedge osc_in or negedge rst_n) begin
      if (!rst_n) begin
         sram_addr0 <= '0;
         sram_din0  <= '0;
         word_cnt   <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         wr_ph      <= '0;
         wr_pend    <= 1'b0;
         closing    <= 1'b0;
         rearm      <= 1'b0;
         ovf        <= 1'b0;
      end else if (start) begin
         sram_addr0 <= '0;
         word_cnt   <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         wr_ph      <= '0;
         wr_pend    <= 1'b0;
         closing    <= 1'b0;
         rearm      <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         if (state == WR) begin
            wr_pend <= 1'b0;
            if (wr_last) begin
               wr_ph      <= '0;
               word_cnt   <= word_cnt + 9'd1;
               sram_addr0 <= sram_addr0 + 8'd1;
               closing    <= wr_close;
               rearm      <= 1'b0;
            end else begin
               wr_ph <= wr_ph + 2'd1;
               if (sload_rise) begin
                  rearm   <= 1'b1;
                  closing <= 1'b0;
               end else if (sload_fall) begin
                  closing <= 1'b1;
                  rearm   <= 1'b0;
               end
            end
         end else if (sload_fall) begin
            closing <= 1'b1;
         end

         if (bit_ev && shifting) begin
            shreg   <= {shreg[29:0], bit_val};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
               if (word_cnt == WORDS_L) begin
                  ovf <= 1'b1;
                  err <= 1'b1;
               end else begin
                  sram_din0 <= {shreg, bit_val};
                  wr_pend   <= 1'b1;
               end
            end
         end

         if (state == FIN && state_nx == IDLE) begin
            done <= (bit_cnt == 5'd0) && !ovf;
            err  <= (bit_cnt != 5'd0) || ovf;
         end
      end
   end

endmodule

// File: doc/hp35_rom_loader.md
HP35_ROM_LOADER -- requirements
Module: hp35_rom_loader

Interface
REQ-001 SHALL have parameter WORDS, default 256: number of 32-bit SRAM words the loader may write (1..256).
REQ-002 SHALL have port osc_in  input  1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have port sload  input  1: external load-frame enable, asynchronous to osc_in, active high.
REQ-005 SHALL have port wclk  input  1: external serial bit clock, asynchronous to osc_in, bit sampled on its rising edge.
REQ-006 SHALL have port sdin  input  1: serial ROM-image data, MSB of each word first.
REQ-007 SHALL have port sram_csb0  output  1: SRAM port-0 chip select, active low.
REQ-008 SHALL have port sram_web0  output  1: SRAM port-0 write enable, active low.
REQ-009 SHALL have port sram_addr0  output  8: SRAM port-0 word address.
REQ-010 SHALL have port sram_din0  output  32: SRAM port-0 write data.
REQ-011 SHALL have port busy  output  1: frame in progress.
REQ-012 SHALL have port done  output  1: last frame closed cleanly; sticky until next frame start or reset.
REQ-013 SHALL have port err  output  1: last frame had a partial word or overflow; sticky until next frame start or reset.
REQ-014 SHALL have port word_cnt  output  9: words written in current/last frame (0..256).

Function
REQ-015 SHALL pass sload, wclk, sdin each through a 2-flop synchronizer on osc_in; sdin delayed to align with wclk.
REQ-016 SHALL detect a wclk bit event as synchronized wclk 0->1; sdin sampled on that same cycle.
REQ-017 SHALL use states IDLE, SHIFT, WR, FIN.
REQ-018 SHALL, on synchronized sload 0->1 from any state, clear word_cnt, bit counter, sram_addr0, done and err, and enter SHIFT one cycle later; busy=1 in SHIFT, WR, FIN.
REQ-019 SHALL, in SHIFT and WR, shift each bit event into a 32-bit shift register (left shift, new bit at LSB) and increment a 5-bit bit counter.
REQ-020 SHALL, on the 32nd bit (counter wraps 31->0), copy the shift register into sram_din0 and enter WR on the next cycle, unless word_cnt==WORDS.
REQ-021 SHALL, in WR, hold sram_csb0=0 and sram_web0=0 for exactly 2 osc_in cycles, with sram_addr0 and sram_din0 stable from 1 cycle before through 1 cycle after the strobe.
REQ-022 SHALL, after WR, increment word_cnt and, one cycle after the strobe deasserts, increment sram_addr0 (wraps 255->0 only when WORDS=256 and frame ends); then return to SHIFT.
REQ-023 SHALL accept bit events arriving during WR without loss (shift register independent of sram_din0).
REQ-024 SHALL, when a 32nd bit completes while word_cnt==WORDS, discard the word, set err=1, never strobe the SRAM again in that frame.
REQ-025 SHALL, on synchronized sload 1->0, enter FIN; FIN waits for any pending WR to complete, then goes to IDLE.
REQ-026 SHALL, on FIN exit, set done=1 if bit counter==0 and no overflow, else err=1 (partial word discarded, not written); done and err never both 1.
REQ-027 SHALL ignore bit events in IDLE and FIN.
REQ-028 SHALL, when sload 1->0 and 0->1 are both detected (re-arm) while in WR, finish the current 2-cycle strobe before restarting.
REQ-029 SHALL drive sram_csb0=1 and sram_web0=1 in every state except WR.

Reset
REQ-030 SHALL, on rst_n=0, immediately force: state IDLE, sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0, busy=0, done=0, err=0, word_cnt=0, shift register, bit counter and synchronizers to 0.
REQ-031 SHALL, if reset asserts during WR, deassert the strobe asynchronously; no write counted.
REQ-032 SHALL leave reset synchronously: first state change no earlier than the second osc_in edge after rst_n rises.

Verification
REQ-033 Frame of 2 words 32'hDEADBEEF, 32'h0123ABCD, then sload low -> two 2-cycle strobes at addr 0 and 1 with those data, word_cnt=2, done=1, err=0.
REQ-034 Frame of 40 bits -> one write at addr 0, sload low -> err=1, done=0, word_cnt=1, no second strobe.
REQ-035 WORDS=4, frame of 5 words -> 4 strobes at addr 0..3, err=1, word_cnt=4.
REQ-036 wclk at max rate (one event per 4 osc_in cycles) across a word boundary -> no bit lost, second word written correctly.
REQ-037 rst_n low during WR strobe -> csb0/web0 high same cycle, all outputs at reset values, next frame starts at addr 0.
REQ-038 Second frame after a done frame -> done and err clear at start, addresses restart at 0.
